// File: rtl/word_mem_ctrl.sv
// Word-to-byte front end for the byte-serial memory: expands one 32-bit request
// into a 4-beat byte frame and reassembles read bytes into a word response.
module word_mem_ctrl #(
    parameter int BEATS = 4,
    parameter int AW    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [AW-1:0]     req_addr,
    input  logic [8*BEATS-1:0] req_wdata,
    output logic              resp_valid,
    output logic [8*BEATS-1:0] resp_rdata,
    output logic [AW-1:0]     mem_address,
    output logic              mem_rw_select,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata
);
    localparam int DW = 8 * BEATS;
    localparam logic [1:0] LAST = 2'(BEATS - 1);

    typedef enum logic [2:0] {IDLE, WBEAT, RBEAT, RTAIL, RESP} state_t;

    state_t          state, state_n;
    logic [1:0]      k, k_n, kn1;
    logic [DW-1:0]   wdata_q, wdata_n;
    logic [DW-9:0]   rbuf, rbuf_n;
    logic            ready_n, resp_n, rw_n;
    logic [DW-1:0]   rdata_n;
    logic [AW-1:0]   addr_n;
    logic [7:0]      wd_n;

    assign kn1 = k + 2'd1;

    // Every output is computed one cycle ahead here and registered below.
    always_comb begin
        state_n = state;
        k_n     = k;
        wdata_n = wdata_q;
        rbuf_n  = rbuf;
        ready_n = 1'b0;
        resp_n  = 1'b0;
        rw_n    = 1'b1;
        wd_n    = 8'h00;
        addr_n  = mem_address;
        rdata_n = resp_rdata;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    k_n     = 2'd0;
                    addr_n  = req_addr;
                    wdata_n = req_wdata;
                    if (req_we) begin
                        state_n = WBEAT;
                        rw_n    = 1'b0;
                        wd_n    = req_wdata[7:0];
                    end else begin
                        state_n = RBEAT;
                    end
                end else begin
                    ready_n = 1'b1;
                end
            end
            WBEAT: begin
                if (k == LAST) begin
                    state_n = RESP;
                    resp_n  = 1'b1;
                end else begin
                    k_n  = kn1;
                    rw_n = 1'b0;
                    wd_n = wdata_q[{kn1, 3'b000} +: 8];
                end
            end
            RBEAT: begin
                // mem_rdata trails the beat by one cycle: beat k carries byte k-1.
                unique case (k)
                    2'd1:    rbuf_n[7:0]   = mem_rdata;
                    2'd2:    rbuf_n[15:8]  = mem_rdata;
                    2'd3:    rbuf_n[23:16] = mem_rdata;
                    default: ;
                endcase
                if (k == LAST) state_n = RTAIL;
                else           k_n     = kn1;
            end
            RTAIL: begin
                state_n = RESP;
                resp_n  = 1'b1;
                rdata_n = {mem_rdata, rbuf};
            end
            RESP: begin
                state_n = IDLE;
                ready_n = 1'b1;
            end
            default: begin
                state_n = IDLE;
                ready_n = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            k             <= 2'd0;
            wdata_q       <= '0;
            rbuf          <= '0;
            req_ready     <= 1'b1;
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
            mem_address   <= '0;
            mem_rw_select <= 1'b1;
            mem_wdata     <= 8'h00;
        end else begin
            state         <= state_n;
            k             <= k_n;
            wdata_q       <= wdata_n;
            rbuf          <= rbuf_n;
            req_ready     <= ready_n;
            resp_valid    <= resp_n;
            resp_rdata    <= rdata_n;
            mem_address   <= addr_n;
            mem_rw_select <= rw_n;
            mem_wdata     <= wd_n;
        end
    end
endmodule

// File: doc/word_mem_ctrl.md
# word_mem_ctrl

Word-level front end for the byte-serial 512-byte memory. Accepts one 32-bit read or write request at a time from the processor/testbench side and expands it into the memory's 4-beat byte frame: 4 sequential byte transfers on the 8-bit memory port. It reassembles read bytes into a 32-bit word and returns a one-cycle response pulse for both reads and writes. Sits directly upstream of the memory: its mem_* outputs drive the memory's address, rw_select and data_in, and it consumes the memory's data_out.

## Interface
Parameters:
- BEATS, 4, bytes per word frame (fixed; not intended to be overridden)
- AW, 8, word address width (memory byte address = {addr, 1'b0} base, as the memory forms it)

Ports:
- clk  in  1  single system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller idle; request accepted when req_valid & req_ready
- req_we  in  1  1 = write, 0 = read
- req_addr  in  8  word address
- req_wdata  in  32  write data; byte k = req_wdata[8k+7:8k]
- resp_valid  out  1  one-cycle pulse: write done / read data valid
- resp_rdata  out  32  assembled read word; holds until next read response
- mem_address  out  8  to memory address
- mem_rw_select  out  1  to memory rw_select (0 write, 1 read)
- mem_wdata  out  8  to memory data_in
- mem_rdata  in  8  from memory data_out

## Operation
- States: IDLE, WBEAT, RBEAT, RTAIL, RESP. 2-bit beat counter `k`.
- IDLE: req_ready=1, mem_rw_select=1, mem_wdata=0. On accept: latch addr, we and wdata. Set k=0 and go to WBEAT (we=1) or RBEAT (we=0).
- WBEAT: mem_rw_select=0, mem_address=latched addr, mem_wdata=byte k. k increments each cycle. After k=3, go to RESP.
- RBEAT: mem_rw_select=1, mem_address=latched addr. Byte k-1 is sampled from mem_rdata at the end of beat k (k≥1). After k=3, go to RTAIL.
- RTAIL: mem_rw_select=1. Sample byte 3, go to RESP.
- RESP: resp_valid=1 for one cycle. For reads, resp_rdata is updated with the assembled word (byte 0 at [7:0], little-endian). Return to IDLE.
- Write responses leave resp_rdata unchanged.
- mem_address and mem_rw_select are held stable for the whole frame. There are no mid-frame changes.
- req_valid and req_we are ignored outside IDLE. A new request is not accepted in the RESP cycle.
- All outputs are registered.

## Timing
- Reset values: req_ready=1, resp_valid=0, resp_rdata=32'h0, mem_address=0, mem_rw_select=1, mem_wdata=0. State=IDLE, k=0.
- Accept in cycle T. Beats occupy T+1..T+4.
- Write: resp_valid at T+5. Total 6 cycles including accept, so the next accept is possible at T+6.
- Read: RTAIL at T+5, resp_valid and new resp_rdata at T+6. The next accept is possible at T+7.
- Read data latency: mem_rdata shows byte k one cycle after beat k starts. The controller samples it on the following edge.
- rst asserted in any state, including mid-frame: the next edge forces the reset values.
  - A partially written frame is abandoned. Bytes already written stay in memory.
  - No resp_valid is produced for the aborted request.
- Back-to-back requests: req_valid held high is accepted again on the first IDLE cycle after RESP.
- req_addr=8'hFF is legal; there is no wrap in the controller.

## Test plan
- Reset: assert rst for 2 cycles mid-write frame. Required: next cycle req_ready=1, mem_rw_select=1, resp_valid=0, resp_rdata=0.
- Write addr 8'h05, wdata 32'hDEADBEEF. Required: mem_wdata sequence EF, BE, AD, DE with mem_rw_select=0 and mem_address=05 for 4 cycles, then resp_valid at T+5.
- Read back addr 8'h05 after that write. Required: resp_valid at T+6 with resp_rdata=32'hDEADBEEF.
- Back-to-back write addr 8'h10 = 32'h01234567, then read addr 8'h10 with req_valid held. Required: read accepted exactly at T+6 and returns 32'h01234567.
- Read of preloaded addr 8'h00. Required: resp_rdata equals {RAM[3], RAM[2], RAM[1], RAM[0]} from the memory's initial image.
- Toggle req_valid/req_we during a read frame. Required: no change on the mem_* outputs, and exactly one resp_valid.
